// File: rtl/uart_pkg.sv
// Shared types and constants for the UART controller family.
package uart_pkg;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } ctrl_state_t;

   localparam int UART_OVERSAMPLE = 16;
   localparam logic [15:0] DEFAULT_DIVISOR = 16'd1;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle tick every max(divisor,1) clocks while run is high.
module uart_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic [DIV_W-1:0] divisor,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] reload;

   // The divisor is only sampled at reload, so a change never truncates a period in flight.
   assign reload = (divisor == '0) ? '0 : divisor - 1'b1;
   assign tick   = run && (cnt_reg == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (!run) begin
         cnt_reg <= '0;
      end else if (cnt_reg == '0) begin
         cnt_reg <= reload;
      end else begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receiver sequencer: owns rx enable and baud tick, buffers bytes in a FWFT FIFO,
// and reports overflow and idle-line timeout.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH        = 8,
   parameter int CNT_W        = $clog2(DEPTH) + 1,
   parameter int DIV_W        = 16,
   parameter int OVERSAMPLE   = uart_pkg::UART_OVERSAMPLE,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [DIV_W-1:0] divisor,
   input  logic             flush,
   input  logic             ovf_clr,
   output logic             rx_enable,
   output logic             baud_tick,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   input  logic             rd_en,
   output logic [7:0]       rd_data,
   output logic             rd_empty,
   output logic [CNT_W-1:0] rd_count,
   output logic             overflow,
   output logic             timeout
);

   localparam int PTR_W    = $clog2(DEPTH);
   localparam int TO_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);

   ctrl_state_t      state_reg, state_next;
   logic             rx_enable_reg;
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             overflow_reg;
   logic [TO_W-1:0]  to_cnt_reg;

   logic empty, full, push, pop, push_ok, drop, to_clear, to_sat;

   assign empty    = (count_reg == '0);
   assign full     = (count_reg == CNT_W'(DEPTH));
   assign push     = rx_valid && (state_reg == RUN);
   assign pop      = rd_en && !empty;
   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign push_ok  = push && (!full || pop);
   assign drop     = push && full && !pop && !flush;
   assign to_clear = push_ok || pop || flush || empty;
   assign to_sat   = (to_cnt_reg >= TO_W'(TO_LIMIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= OFF;
         rx_enable_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         rx_enable_reg <= (state_reg == RUN);
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         OFF:     if (ena) state_next = RUN;
         RUN:     if (!ena) state_next = empty ? OFF : DRAIN;
         DRAIN: begin
            if (ena)        state_next = RUN;
            else if (empty) state_next = OFF;
         end
         default: state_next = OFF;
      endcase
   end

   uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state_reg == RUN),
      .divisor (divisor),
      .tick    (baud_tick)
   );

   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr_reg] <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
         else if (pop && !push_ok) count_reg <= count_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_reg <= 1'b0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
      end else if (ovf_clr) begin
         overflow_reg <= 1'b0;
      end
   end

   // Counts idle ticks with data pending; ticks only exist in RUN, so it freezes elsewhere.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt_reg <= '0;
      end else if (to_clear) begin
         to_cnt_reg <= '0;
      end else if (baud_tick && !to_sat) begin
         to_cnt_reg <= to_cnt_reg + 1'b1;
      end
   end

   assign rx_enable = rx_enable_reg;
   assign rd_data   = mem[rd_ptr_reg];
   assign rd_empty  = empty;
   assign rd_count  = count_reg;
   assign overflow  = overflow_reg;
   assign timeout   = to_sat;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; a negedge monitor checks popped bytes against a scoreboard queue.
module tb_uart_rx_ctrl;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n, ena, flush, ovf_clr, rx_valid, rd_en;
   logic [15:0]      divisor;
   logic [7:0]       rx_data, rd_data;
   logic             rx_enable, baud_tick, rd_empty, overflow, timeout;
   logic [CNT_W-1:0] rd_count;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .divisor   (divisor),
      .flush     (flush),
      .ovf_clr   (ovf_clr),
      .rx_enable (rx_enable),
      .baud_tick (baud_tick),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_empty  (rd_empty),
      .rd_count  (rd_count),
      .overflow  (overflow),
      .timeout   (timeout)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accept);
      rx_data  = b;
      rx_valid = 1'b1;
      step();
      rx_valid = 1'b0;
      if (accept) sb.push_back(b);
      $display("push 0x%02h expect_accept=%0d count=%0d", b, accept, rd_count);
   endtask

   task automatic pop_byte();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic wait_tick(output int gap);
      gap = 0;
      do begin
         step();
         gap++;
      end while (!baud_tick && gap < 64);
   endtask

   // Monitor: every real pop is compared against the oldest expected byte.
   always @(negedge clk) begin
      if (rst_n && rd_en && !rd_empty) begin
         if (sb.size() == 0) begin
            check("pop_unexpected", 1, 0);
         end else begin
            automatic logic [7:0] exp_b = sb.pop_front();
            $display("pop got 0x%02h expect 0x%02h", rd_data, exp_b);
            check("pop_data", int'(rd_data), int'(exp_b));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      int n;
      rst_n = 1'b0; ena = 1'b0; divisor = 16'd4; flush = 1'b0; ovf_clr = 1'b0;
      rx_data = 8'h00; rx_valid = 1'b0; rd_en = 1'b0;
      repeat (3) step();
      check("rst_empty", rd_empty, 1);
      check("rst_count", rd_count, 0);
      check("rst_rx_enable", rx_enable, 0);
      check("rst_tick", baud_tick, 0);
      check("rst_overflow", overflow, 0);
      check("rst_timeout", timeout, 0);
      rst_n = 1'b1;
      step();

      // Tick generation and divisor change
      ena = 1'b1;
      step();
      check("tick_on_run_entry", baud_tick, 1);
      check("rx_enable_lag", rx_enable, 0);
      step();
      check("rx_enable_on", rx_enable, 1);
      wait_tick(gap);
      check("tick_gap_div4", gap, 3);
      step();
      divisor = 16'd2;
      wait_tick(gap);
      check("tick_gap_old_period", gap, 3);
      wait_tick(gap);
      check("tick_gap_div2_a", gap, 2);
      wait_tick(gap);
      check("tick_gap_div2_b", gap, 2);

      // Fill and read
      push_byte(8'hA5, 1);
      push_byte(8'h3C, 1);
      push_byte(8'h7E, 1);
      check("fill_count", rd_count, 3);
      check("fill_head", rd_data, 8'hA5);
      repeat (3) pop_byte();
      check("read_empty", rd_empty, 1);
      pop_byte();
      check("underflow_count", rd_count, 0);

      // Overflow, with clear coinciding with the drop
      for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1);
      ovf_clr = 1'b1;
      push_byte(8'h08, 0);
      ovf_clr = 1'b0;
      check("full_count", rd_count, 8);
      check("ovf_set_wins", overflow, 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_cleared", overflow, 0);
      rx_data = 8'h99; rx_valid = 1'b1; rd_en = 1'b1;
      step();
      rx_valid = 1'b0; rd_en = 1'b0;
      sb.push_back(8'h99);
      check("full_pushpop_count", rd_count, 8);
      check("full_pushpop_no_ovf", overflow, 0);
      repeat (DEPTH) pop_byte();
      check("ovf_drained", rd_empty, 1);

      // Timeout at 640 ticks with divisor 1
      divisor = 16'd1;
      repeat (4) step();
      push_byte(8'h55, 1);
      repeat (639) step();
      check("timeout_pre", timeout, 0);
      step();
      check("timeout_set", timeout, 1);
      pop_byte();
      check("timeout_clr_on_pop", timeout, 0);
      check("timeout_pop_empty", rd_empty, 1);
      push_byte(8'h66, 1);
      repeat (639) step();
      check("timeout_restart_pre", timeout, 0);
      step();
      check("timeout_restart_set", timeout, 1);
      pop_byte();

      // Drain to OFF
      divisor = 16'd4;
      repeat (4) step();
      push_byte(8'h11, 1);
      push_byte(8'h22, 1);
      ena = 1'b0;
      step();
      step();
      check("drain_rx_enable", rx_enable, 0);
      n = 0;
      repeat (8) begin
         step();
         n += int'(baud_tick);
      end
      check("drain_no_ticks", n, 0);
      push_byte(8'h33, 0);
      check("drain_push_ignored", rd_count, 2);
      pop_byte();
      pop_byte();
      check("drain_empty", rd_empty, 1);
      repeat (2) step();
      check("off_rx_enable", rx_enable, 0);

      // Drain back to RUN with FIFO intact
      ena = 1'b1;
      repeat (3) step();
      push_byte(8'h44, 1);
      push_byte(8'h5A, 1);
      ena = 1'b0;
      repeat (2) step();
      check("drain2_rx_enable", rx_enable, 0);
      ena = 1'b1;
      repeat (2) step();
      check("rerun_rx_enable", rx_enable, 1);
      check("rerun_count", rd_count, 2);
      pop_byte();
      pop_byte();

      // Flush beats push and keeps overflow
      for (int i = 0; i <= DEPTH; i++) push_byte(8'(8'h80 + i), i < DEPTH);
      check("flush_pre_ovf", overflow, 1);
      pop_byte();
      flush = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
      step();
      flush = 1'b0; rx_valid = 1'b0;
      sb.delete();
      check("flush_count", rd_count, 0);
      check("flush_empty", rd_empty, 1);
      check("flush_keeps_ovf", overflow, 1);

      // Asynchronous reset mid-fill
      push_byte(8'h01, 1);
      push_byte(8'h02, 1);
      #3;
      rst_n = 1'b0;
      #1;
      sb.delete();
      check("arst_count", rd_count, 0);
      check("arst_empty", rd_empty, 1);
      check("arst_overflow", overflow, 0);
      check("arst_rx_enable", rx_enable, 0);
      check("arst_tick", baud_tick, 0);
      check("arst_timeout", timeout, 0);
      step();
      rst_n = 1'b1;
      step();
      check("post_arst_empty", rd_empty, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
